// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encoding, byte order
// of the serial stream, and the header range check.
package prog_loader_pkg;

   typedef enum logic [1:0] {
      ST_HDR  = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } load_state_e;

   // First byte on the wire lands in bits [31:24] when set.
   localparam bit BYTE_ORDER_BIG_ENDIAN = 1'b1;

   localparam int WORD_BYTES = 4;

   // A header word count is usable when 1 <= n <= 2^addr_w.
   function automatic logic header_ok(input logic [31:0] n, input int addr_w);
      logic [32:0] capacity;
      capacity = 33'd1 << addr_w;
      return (n != 32'd0) && ({1'b0, n} <= capacity);
   endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Collects four serial bytes into a 32-bit word. word/word_valid are
// combinational on the handshake of the fourth byte so the parent can
// register the write one cycle after that handshake.
module byte_packer
   import prog_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_data,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  byte_cnt;
   logic [23:0] shreg;
   logic [23:0] shreg_next;

   // Merge the held bytes with the incoming one in wire order.
   always_comb begin
      shreg_next = shreg;
      word       = '0;
      if (BYTE_ORDER_BIG_ENDIAN) begin
         shreg_next = {shreg[15:0], byte_data};
         word       = {shreg, byte_data};
      end else begin
         shreg_next = {byte_data, shreg[23:8]};
         word       = {byte_data, shreg};
      end
   end

   assign word_valid = byte_en && (byte_cnt == 2'd3);

   // Byte counter wraps 3 -> 0 on each completed word; partial words
   // are dropped on reset or restart.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_cnt <= 2'd0;
         shreg    <= '0;
      end else if (clear) begin
         byte_cnt <= 2'd0;
         shreg    <= '0;
      end else if (byte_en) begin
         byte_cnt <= byte_cnt + 2'd1;
         if (byte_cnt == 2'd3) begin
            shreg <= '0;
         end else begin
            shreg <= shreg_next;
         end
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: takes a byte stream (word count header then
// program words), writes the words to instruction memory from address 0
// and holds the CPU in reset until the whole program is in place.
//
// state | meaning
// HDR   | assembling the header word (word count N)
// LOAD  | writing program words to addresses 0..N-1
// DONE  | program loaded, CPU released, waits for load_start
// ERR   | header count out of range, CPU held, waits for load_start
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

   load_state_e       state;
   logic [ADDR_W:0]   word_count;
   logic [ADDR_W-1:0] addr_cnt;
   logic              last_pending;

   logic              byte_en;
   logic              restart;
   logic              word_valid;
   logic [31:0]       word;
   logic              is_last;

   assign byte_ready = (state == ST_HDR) || (state == ST_LOAD);
   assign byte_en    = byte_valid && byte_ready;
   assign restart    = load_start && ((state == ST_DONE) || (state == ST_ERR));
   assign cpu_hold   = (state != ST_DONE);
   assign done       = (state == ST_DONE);
   assign err        = (state == ST_ERR);
   assign is_last    = ({1'b0, addr_cnt} == (word_count - (ADDR_W+1)'(1)));

   byte_packer u_byte_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (restart),
      .byte_en    (byte_en),
      .byte_data  (byte_data),
      .word_valid (word_valid),
      .word       (word)
   );

   // Loader FSM, address/word counters and the registered write port.
   // DONE is entered the cycle after the final imem_we so the last write
   // completes while the CPU is still held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_HDR;
         word_count   <= '0;
         addr_cnt     <= '0;
         last_pending <= 1'b0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            ST_HDR: begin
               if (word_valid) begin
                  if (header_ok(word, ADDR_W)) begin
                     state      <= ST_LOAD;
                     word_count <= word[ADDR_W:0];
                  end else begin
                     state <= ST_ERR;
                  end
               end
            end
            ST_LOAD: begin
               if (last_pending) begin
                  last_pending <= 1'b0;
                  state        <= ST_DONE;
               end else if (word_valid) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= addr_cnt;
                  imem_wdata <= word;
                  if (is_last) begin
                     last_pending <= 1'b1;
                  end else begin
                     addr_cnt <= addr_cnt + 1'b1;
                  end
               end
            end
            ST_DONE, ST_ERR: begin
               if (load_start) begin
                  state        <= ST_HDR;
                  word_count   <= '0;
                  addr_cnt     <= '0;
                  last_pending <= 1'b0;
               end
            end
            default: begin
               state <= ST_HDR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader.
module tb_prog_loader;

   localparam int ADDR_W = 12;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk;
   logic              rst;
   logic              load_start;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              err;

   prog_loader #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] preset_q[$];
   wr_t         mon_e;
   int          checks = 0;
   int          errors = 0;
   bit          gaps_on = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (rst === 1'b1 && imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0h data %0h, expected no write", imem_addr, imem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            check("write_addr", 64'(imem_addr), 64'(mon_e.addr));
            check("write_data", 64'(imem_wdata), 64'(mon_e.data));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      if (gaps_on) begin
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            byte_valid = 1'b0;
         end
      end
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
   endtask

   task automatic idle();
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
   endtask

   // Reference model: a header of n is accepted iff 1 <= n <= DEPTH, then
   // word i goes to address i; error latency 1 cycle after the last header
   // byte is visible, done visible 2 cycles after the last program byte.
   task automatic run_load(input logic [31:0] n, input bit inject_start);
      bit          ok;
      logic [31:0] w;
      int          lat;
      ok = (n >= 32'd1) && (n <= 32'(DEPTH));
      send_word(n);
      if (ok) begin
         for (int i = 0; i < int'(n); i++) begin
            if (inject_start && i == int'(n) / 2) begin
               @(negedge clk);
               byte_valid = 1'b0;
               load_start = 1'b1;
               @(negedge clk);
               load_start = 1'b0;
            end
            if (preset_q.size() != 0) w = preset_q.pop_front();
            else w = $urandom;
            send_word(w);
            exp_q.push_back('{addr: ADDR_W'(i), data: w});
         end
      end
      idle();
      lat = 1;
      while (!(done === 1'b1 || err === 1'b1) && lat < 6) begin
         @(negedge clk);
         lat++;
      end
      check("end_latency", 64'(lat), ok ? 64'd2 : 64'd1);
      check("end_done", 64'(done), ok ? 64'd1 : 64'd0);
      check("end_err", 64'(err), ok ? 64'd0 : 64'd1);
      check("end_cpu_hold", 64'(cpu_hold), ok ? 64'd0 : 64'd1);
      check("end_byte_ready", 64'(byte_ready), 64'd0);
      check("writes_pending", 64'(exp_q.size()), 64'd0);
      // Bytes offered while finished are not taken.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         byte_valid = 1'b1;
         byte_data  = 8'($urandom);
      end
      @(negedge clk);
      byte_valid = 1'b0;
      check("hold_done", 64'(done), ok ? 64'd1 : 64'd0);
      check("hold_err", 64'(err), ok ? 64'd0 : 64'd1);
      // Restart.
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      check("restart_state", 64'({done, err, cpu_hold, byte_ready}), 64'b0011);
      exp_q.delete();
   endtask

   initial begin
      logic [31:0] n;
      int          kind;
      rst        = 1'b0;
      load_start = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_byte_ready", 64'(byte_ready), 64'd1);
      check("rst_imem_we", 64'(imem_we), 64'd0);
      check("rst_imem_addr", 64'(imem_addr), 64'd0);
      check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
      check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
      check("rst_done_err", 64'({done, err}), 64'd0);
      rst = 1'b1;

      // Two fixed words back-to-back.
      gaps_on = 1'b0;
      preset_q.push_back(32'hDEADBEEF);
      preset_q.push_back(32'h01234567);
      run_load(32'd2, 1'b0);

      // Reload of one word overwrites address 0.
      gaps_on = 1'b1;
      run_load(32'd1, 1'b0);

      // Out-of-range headers.
      run_load(32'd0, 1'b0);
      run_load(32'h0000_1001, 1'b0);
      run_load(32'h0001_0001, 1'b0);

      // Reset in the middle of word 1.
      gaps_on = 1'b0;
      send_word(32'd2);
      send_byte(8'hA5);
      send_byte(8'h5A);
      idle();
      rst = 1'b0;
      #1;
      check("midrst_imem_we", 64'(imem_we), 64'd0);
      check("midrst_state", 64'({done, err, cpu_hold, byte_ready}), 64'b0011);
      check("midrst_addr", 64'(imem_addr), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      run_load(32'd1, 1'b0);

      // Random loads, some with an ignored load_start mid-load.
      for (int s = 0; s < 10; s++) begin
         gaps_on = 1'($urandom_range(0, 1));
         kind = $urandom_range(0, 9);
         if (kind < 3) begin
            case ($urandom_range(0, 2))
               0:       n = 32'd0;
               1:       n = 32'(DEPTH + 1) + 32'($urandom_range(0, 100));
               default: n = $urandom | 32'h0001_0000;
            endcase
         end else begin
            n = 32'($urandom_range(1, 24));
         end
         run_load(n, ($urandom_range(0, 2) == 0) && (n >= 32'd2) && (n <= 32'd24));
      end

      // Full capacity, last address written without wrap.
      gaps_on = 1'b0;
      run_load(32'(DEPTH), 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 12, instruction-memory word-address width; capacity is 2^ADDR_W words.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 load_start  input  1  one-cycle pulse; restarts loading from DONE or ERR.
REQ-005 byte_valid  input  1  byte_data is valid this cycle.
REQ-006 byte_data  input  8  serial program byte.
REQ-007 byte_ready  output  1  loader accepts a byte this cycle.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  word address of the current write.
REQ-010 imem_wdata  output  32  word being written.
REQ-011 cpu_hold  output  1  high holds the CPU in reset; low releases it.
REQ-012 done  output  1  high while in DONE.
REQ-013 err  output  1  high while in ERR.

Function
REQ-014 A byte transfer occurs only on a cycle where byte_valid and byte_ready are both 1.
REQ-015 States: HDR, LOAD, DONE, ERR.
REQ-016 Words are assembled big-endian; the first byte accepted becomes bits [31:24].
REQ-017 A 2-bit byte counter wraps 3 to 0 on each completed word.
REQ-018 In HDR, the first complete word is the word count N.
REQ-019 If 1 <= N <= 2^ADDR_W, the block goes to LOAD; otherwise (N = 0 or N > 2^ADDR_W) it goes to ERR.
REQ-020 In LOAD, each completed word is written to addresses 0, 1, ..., N-1 in order.
REQ-021 imem_we asserts for exactly one cycle, the cycle after the fourth byte of a word is accepted.
REQ-022 imem_addr and imem_wdata are registered and stable during that imem_we cycle.
REQ-023 Write latency from the fourth-byte handshake to imem_we is 1 cycle.
REQ-024 byte_ready is 1 in HDR and LOAD, including during imem_we cycles, so back-to-back bytes are accepted with no bubble.
REQ-025 byte_ready is 0 in DONE and ERR.
REQ-026 After the write of word N-1 is issued, the next state is DONE; the address counter never exceeds N-1.
REQ-027 The word counter is ADDR_W+1 bits wide so that N = 2^ADDR_W is representable.
REQ-028 The address counter is ADDR_W bits wide; the last address 2^ADDR_W-1 is written without wrap.
REQ-029 cpu_hold is 1 in HDR, LOAD and ERR, and 0 only in DONE.
REQ-030 load_start in DONE or ERR moves the state to HDR and clears the byte, word and address counters; cpu_hold rises the same cycle the state becomes HDR.
REQ-031 load_start in HDR or LOAD is ignored.
REQ-032 byte_valid held high in DONE or ERR transfers no byte and changes no state.

Reset
REQ-033 Asserting rst (low) at any time, including mid-word or mid-load, forces HDR and zeroes all counters and the assembly register.
REQ-034 Reset values: byte_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, err=0.
REQ-035 A partially received word is discarded on reset and never written.

Structure
REQ-036 The state encoding enum and the big-endian byte-order constant live in the shared CPU package.
REQ-037 One sub-module, byte_packer (4-byte shift register plus byte counter, emitting a word_valid pulse), is instantiated inside prog_loader.
REQ-038 imem_we, imem_addr and imem_wdata connect to the write port of READ_ONLY_MEM; cpu_hold drives the CPU reset.

Verification
REQ-039 Header 00000002, words DEADBEEF and 01234567 sent back-to-back -> imem_we at addr 0 with DEADBEEF, then addr 1 with 01234567; next cycle done=1, cpu_hold=0.
REQ-040 Header 00000000 -> err=1, byte_ready=0, cpu_hold=1, no imem_we.
REQ-041 Header 00001001 with ADDR_W=12 -> err=1.
REQ-042 Header 00001000 followed by 4096 words -> last write at addr FFF, then done=1.
REQ-043 rst asserted after 2 bytes of word 1 -> HDR, imem_we=0; a fresh header 00000001 plus one word -> single write at addr 0.
REQ-044 In DONE, a load_start pulse -> HDR, cpu_hold=1; a reload of 1 word overwrites addr 0.
